mux_n_pipe: RTL and testbench

//   Parametrised N:1 word multiplexer with a registered, valid/ready-handshaked output stage.
//   It replaces the 1-bit combinational 16:1 select in pipeline paths that need full-width

---
 rtl/mux_n_pipe.sv | 110 +++++++++++
 tb/tb_mux_n_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// N:1 word multiplexer feeding a registered valid/ready output stage.
// A main register drives out_*; one skid register absorbs a single stalled beat.
module mux_n_pipe #(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       N           = 16,
    parameter int unsigned       SEL_W       = 4,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    if ((N < 2) || (N > 256) || (N > (32'd1 << SEL_W))) begin : g_param_check
        $error("mux_n_pipe: N must be in 2..256 and fit in SEL_W select bits");
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } entry_t;

    entry_t           r_main;
    entry_t           r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    entry_t           w_in_entry;
    logic             w_in_xfer;
    entry_t           w_main_nxt;
    entry_t           w_skid_nxt;
    logic             w_main_valid_nxt;
    logic             w_skid_valid_nxt;

    // Out-of-range selects fall through to DEFAULT_VAL.
    always_comb begin
        w_sel_data = DEFAULT_VAL;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(in_sel) == k) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel_err  = (32'(in_sel) >= N);
    assign w_in_entry = '{data: w_sel_data, sel: in_sel, err: w_sel_err};
    assign w_in_xfer  = in_valid & r_in_ready;

    always_comb begin
        w_main_nxt       = r_main;
        w_main_valid_nxt = r_main_valid;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid || out_ready) begin
            // Main is empty or draining; the skid is only ever full when main is full.
            if (r_skid_valid) begin
                w_main_nxt       = r_skid;
                w_main_valid_nxt = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_xfer) begin
                w_main_nxt       = w_in_entry;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_in_xfer) begin
            w_skid_nxt       = w_in_entry;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_main.data;
    assign out_sel   = r_main.sel;
    assign out_err   = r_main.err;
    assign out_valid = r_main_valid;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench: queue-based reference of the 2-deep handshaked mux,
// shared by a 16-lane and a 12-lane instance driven from the same stimulus.
module tb_mux_n_pipe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [511:0] in_data = '0;
    logic [3:0]   in_sel = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;

    logic         rdy16, rdy12, ov16, ov12, err16, err12;
    logic [31:0]  od16, od12;
    logic [3:0]   os16, os12;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    bit           chk_en = 1'b0;

    always #5 clk = ~clk;

    mux_n_pipe #(.WIDTH(32), .N(16), .SEL_W(4), .DEFAULT_VAL(32'h0)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(rdy16), .out_data(od16), .out_sel(os16),
        .out_err(err16), .out_valid(ov16), .out_ready(out_ready)
    );

    mux_n_pipe #(.WIDTH(32), .N(12), .SEL_W(4), .DEFAULT_VAL(32'h0)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data[12*32-1:0]), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(rdy12), .out_data(od12), .out_sel(os12),
        .out_err(err12), .out_valid(ov12), .out_ready(out_ready)
    );

    typedef struct packed {
        logic [31:0] d16;
        logic [31:0] d12;
        logic        e12;
        logic [3:0]  sel;
    } ent_t;

    ent_t q[$];
    ent_t m_main = '0;
    bit   m_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [511:0] d, input logic [3:0] s);
        ent_t        e;
        logic [31:0] lane;
        lane  = d[s*32 +: 32];
        e.d16 = lane;
        e.d12 = (s < 12) ? lane : 32'h0;
        e.e12 = (s >= 12);
        e.sel = s;
        return e;
    endfunction

    // Reference: the block is a FIFO of depth 2 whose ready reflects the
    // occupancy after the previous edge; the head is what the outputs show.
    task automatic model_edge();
        bit   ix;
        bit   ox;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_main = '0;
            m_rdy  = 1'b0;
        end else begin
            ix = in_valid && m_rdy;
            ox = (q.size() > 0) && out_ready;
            e  = mk(in_data, in_sel);
            if (ox) void'(q.pop_front());
            if (flush) q.delete();
            else if (ix) q.push_back(e);
            if (q.size() > 0) m_main = q[0];
            m_rdy = (q.size() < 2);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("in_ready16", {63'd0, rdy16}, {63'd0, m_rdy});
            chk("in_ready12", {63'd0, rdy12}, {63'd0, m_rdy});
            chk("out_valid16", {63'd0, ov16}, {63'd0, (q.size() > 0)});
            chk("out_valid12", {63'd0, ov12}, {63'd0, (q.size() > 0)});
            chk("out_data16", {32'd0, od16}, {32'd0, m_main.d16});
            chk("out_data12", {32'd0, od12}, {32'd0, m_main.d12});
            chk("out_sel16", {60'd0, os16}, {60'd0, m_main.sel});
            chk("out_sel12", {60'd0, os12}, {60'd0, m_main.sel});
            chk("out_err16", {63'd0, err16}, 64'd0);
            chk("out_err12", {63'd0, err12}, {63'd0, m_main.e12});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [31:0] v);
        in_data[k*32 +: 32] = v;
    endtask

    initial begin
        // Reset state
        step();
        chk_en = 1'b1;
        step();
        chk("rst_out_valid", {63'd0, ov16}, 64'd0);
        chk("rst_out_data", {32'd0, od16}, 64'd0);
        chk("rst_in_ready", {63'd0, rdy16}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("release_in_ready", {63'd0, rdy16}, 64'd1);

        // Streaming sel 0..15 at full rate
        for (int k = 0; k < 16; k++) set_lane(k, 32'h1000_0000 + 32'(k));
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_sel   = 4'(k);
            step();
            chk("stream_valid", {63'd0, ov16}, 64'd1);
            chk("stream_data", {32'd0, od16}, {32'd0, 32'h1000_0000 + 32'(k)});
            chk("stream_sel", {60'd0, os16}, {60'd0, 4'(k)});
        end
        chk("model_stream_last", {32'd0, m_main.d16}, {32'd0, 32'h1000_000F});
        in_valid = 1'b0;
        step();
        chk("stream_drained", {63'd0, ov16}, 64'd0);

        // Out-of-range select on the 12-lane instance
        in_valid = 1'b1;
        in_sel   = 4'd13;
        step();
        chk("oor_data", {32'd0, od12}, 64'd0);
        chk("oor_err", {63'd0, err12}, 64'd1);
        chk("oor_sel", {60'd0, os12}, 64'd13);
        chk("model_oor_err", {63'd0, m_main.e12}, 64'd1);
        in_sel = 4'd11;
        step();
        chk("top_lane_err", {63'd0, err12}, 64'd0);
        chk("top_lane_data", {32'd0, od12}, {32'd0, 32'h1000_000B});
        in_valid = 1'b0;
        step();

        // Backpressure fills main then skid
        out_ready = 1'b0;
        set_lane(1, 32'hAAAA_0001);
        set_lane(2, 32'hBBBB_0002);
        in_valid = 1'b1;
        in_sel   = 4'd1;
        step();
        in_sel   = 4'd2;
        step();
        in_valid = 1'b0;
        chk("bp_in_ready", {63'd0, rdy16}, 64'd0);
        chk("bp_hold_a", {32'd0, od16}, {32'd0, 32'hAAAA_0001});
        chk("model_bp_head", {32'd0, m_main.d16}, {32'd0, 32'hAAAA_0001});
        step();
        chk("bp_still_a", {32'd0, od16}, {32'd0, 32'hAAAA_0001});
        out_ready = 1'b1;
        step();
        chk("bp_then_b", {32'd0, od16}, {32'd0, 32'hBBBB_0002});
        chk("bp_ready_back", {63'd0, rdy16}, 64'd1);
        step();
        chk("bp_empty", {63'd0, ov16}, 64'd0);

        // Flush with both entries full and an offered input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 4'd1;
        step();
        in_sel    = 4'd2;
        step();
        chk("fl_full", {63'd0, rdy16}, 64'd0);
        set_lane(3, 32'hCCCC_0003);
        in_sel = 4'd3;
        flush  = 1'b1;
        step();
        chk("fl_out_valid", {63'd0, ov16}, 64'd0);
        chk("fl_in_ready", {63'd0, rdy16}, 64'd1);
        // Flush while an input actually transfers: it must be dropped
        flush = 1'b0;
        in_sel = 4'd1;
        step();
        in_sel = 4'd3;
        flush  = 1'b1;
        step();
        chk("fl2_out_valid", {63'd0, ov16}, 64'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl_c_never", {63'd0, ov16}, 64'd0);

        // Reset with two entries buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 4'd1;
        step();
        in_sel    = 4'd2;
        step();
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        step();
        chk("mr_out_valid", {63'd0, ov16}, 64'd0);
        chk("mr_out_data", {32'd0, od16}, 64'd0);
        chk("mr_in_ready", {63'd0, rdy16}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("mr_in_ready_back", {63'd0, rdy16}, 64'd1);
        chk("mr_still_empty", {63'd0, ov16}, 64'd0);

        // Random handshake soak against the reference queue
        for (int i = 0; i < 10000; i++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = (i % 2000 < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            in_sel    = 4'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) set_lane(k, $urandom);
            step();
        end
        rst_n    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
